pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage of the multi-cycle processor, directly downstream of `branch_control`. It consumes the resolved 2-bit PC-source select and computes the next PC from the sequential, branch, jump and jump-register targets. It then runs a request/acknowledge fetch to instruction memory and presents the fetched instruction to decode. It holds each instruction until the datapath signals that the instruction's PC source is resolved.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- inClk  in  1  clock; all state changes on the rising edge.
- inReset  in  1  synchronous reset, active-high.
- inPCsrc  in  2  next-PC select from `branch_control`: 00 PC+4, 01 jump, 10 branch, 11 jump-register.
- inImm  in  16  branch word offset, signed.
- inJumpTarget  in  26  J/JAL instruction index.
- inRegTarget  in  32  rs value for JR.
- inResolve  in  1  current instruction's inPCsrc and target inputs are valid this cycle.
- inStall  in  1  blocks the PC update while high.
- inImemAck  in  1  instruction memory accepts the request; inImemData is valid this cycle.
- inImemData  in  32  fetched instruction word.
- outImemReq  out  1  fetch request.
- outImemAddr  out  32  fetch address; equals outPC.
- outInstr  out  32  latched instruction.
- outInstrValid  out  1  outInstr is valid for decode.
- outPC  out  32  PC of the current instruction.
- outPCPlus4  out  32  outPC + 4, used for the JAL link.
- outFault  out  1  sticky misaligned-target fault.

## Operation
- FSM states: S_FETCH, S_EXEC, S_HALT.
- Reset: PC = RESET_PC, state S_FETCH, outImemReq = 0, outInstr = 0, outInstrValid = 0, outFault = 0.
- S_FETCH: outImemReq = 1 and outImemAddr = PC, both held until inImemAck.
  - On ack: outInstr <= inImemData, outInstrValid <= 1, outImemReq <= 0, go to S_EXEC.
  - inStall and inResolve are ignored in S_FETCH.
- S_EXEC: outInstr and outPC are held.
  - On inResolve & !inStall, compute next PC (rules below) and check alignment.
  - Aligned (next[1:0] == 00): PC <= next, outInstrValid <= 0, outImemReq <= 1, go to S_FETCH.
  - Misaligned: PC unchanged, outFault <= 1, outInstrValid <= 0, go to S_HALT.
  - inResolve with inStall: no state change; the instruction is re-evaluated on the next cycle.
- S_HALT: no requests; only inReset exits.
- inImemAck outside S_FETCH is ignored.
- Next-PC arithmetic, all modulo 2^32:
  - seq = PC + 4.
  - branch = seq + (sign_extend(inImm) << 2).
  - jump = {seq[31:28], inJumpTarget, 2'b00}.
  - jr = inRegTarget.
- Wrap-around: PC = 32'hFFFF_FFFC with select 00 gives 32'h0000_0000, and no fault is raised.

## Timing
- outImemReq rises in the first cycle after inReset deasserts.
- Ack in cycle N: outInstrValid = 1 and outInstr valid in cycle N+1.
- Resolve (not stalled) in cycle M: new outPC and outImemReq = 1 in cycle M+1.
- A 0-wait-state memory (ack in the same cycle as req) gives a 2-cycle fetch-to-fetch minimum, plus however long inResolve takes.
- Ack in the same cycle as the request is legal.
- All outputs are registered; none depends combinationally on inputs.
- Reset mid-fetch: outImemReq = 0 in the next cycle; an ack in the reset cycle is discarded.
- Reset mid-exec: the pending resolve is discarded.

## Structure
- Shared processor package holds:
  - PCSRC_SEQ = 2'b00, PCSRC_JUMP = 2'b01, PCSRC_BRANCH = 2'b10, PCSRC_JR = 2'b11, also used by control and `branch_control`.
  - FSM state encoding.
  - Instruction/address width constant, 32.
- One combinational sub-module, `next_pc_calc`: inputs PC, select, imm, jump target, reg target; outputs next PC and misaligned flag.
- FSM and registers live in pc_fetch_unit.

## Test plan
- Reset, ack in the same cycle as each request, resolve with 00 → addresses 0x0, 0x4, 0x8; outInstrValid rises 1 cycle after each ack.
- PC = 0x100, select 10, imm = 16'hFFFE → next fetch at 0x0FC.
- PC = 0x100, select 10, imm = 16'h0003 → next fetch at 0x110.
- PC = 0x4000_0010, select 01, target 26'h0000040 → next fetch at 0x4000_0100.
- Select 11, inRegTarget = 0x0000_0202 → outFault = 1, state S_HALT, no further requests; inReset clears the fault and refetches from RESET_PC.
- Stall during resolve:
  - inResolve with inStall high for 3 cycles → PC and outInstr unchanged throughout.
  - inStall low → update on the next edge.
- Late ack and reset:
  - Ack 5 cycles after the request → outImemAddr stable throughout the wait.
  - Reset asserted while the request is pending, with ack in the reset cycle → ack ignored, outInstrValid stays 0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared processor definitions: PC-source select codes, fetch FSM encoding and
// the architectural word/address width.
package pc_fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_JUMP   = 2'b01;
    localparam logic [1:0] PCSRC_BRANCH = 2'b10;
    localparam logic [1:0] PCSRC_JR     = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_HALT  = 2'b10
    } fetchStateT;

    function automatic logic isWordAligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, jump and jump-register
// targets, plus a flag for a target that is not word-aligned.
module next_pc_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pcSrc,
    input  logic [15:0]     imm,
    input  logic [25:0]     jumpTarget,
    input  logic [XLEN-1:0] regTarget,
    output logic [XLEN-1:0] nextPc,
    output logic            misaligned
);

    logic        [XLEN-1:0] seqPc;
    logic signed [15:0]     immS;
    logic signed [XLEN-1:0] branchOffset;
    logic        [XLEN-1:0] branchPc;
    logic        [XLEN-1:0] jumpPc;

    assign seqPc        = pc + 32'd4;
    assign immS         = imm;
    // Word offset: sign-extend then scale by 4; all sums wrap modulo 2^32.
    assign branchOffset = {{(XLEN-18){immS[15]}}, immS, 2'b00};
    assign branchPc     = seqPc + $unsigned(branchOffset);
    assign jumpPc       = {seqPc[31:28], jumpTarget, 2'b00};

    always_comb begin
        nextPc = seqPc;
        case (pcSrc)
            PCSRC_SEQ:    nextPc = seqPc;
            PCSRC_JUMP:   nextPc = jumpPc;
            PCSRC_BRANCH: nextPc = branchPc;
            PCSRC_JR:     nextPc = regTarget;
            default:      nextPc = seqPc;
        endcase
    end

    assign misaligned = !isWordAligned(nextPc);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and request/acknowledge instruction fetch; holds each fetched
// instruction until its PC source resolves, then fetches the next one.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            inClk,
    input  logic            inReset,
    input  logic [1:0]      inPCsrc,
    input  logic [15:0]     inImm,
    input  logic [25:0]     inJumpTarget,
    input  logic [XLEN-1:0] inRegTarget,
    input  logic            inResolve,
    input  logic            inStall,
    input  logic            inImemAck,
    input  logic [XLEN-1:0] inImemData,
    output logic            outImemReq,
    output logic [XLEN-1:0] outImemAddr,
    output logic [XLEN-1:0] outInstr,
    output logic            outInstrValid,
    output logic [XLEN-1:0] outPC,
    output logic [XLEN-1:0] outPCPlus4,
    output logic            outFault
);

    fetchStateT      state, stateNext;
    logic [XLEN-1:0] pcQ, pcNext;
    logic [XLEN-1:0] pcPlus4Q, pcPlus4Next;
    logic [XLEN-1:0] instrQ, instrNext;
    logic            instrValidQ, instrValidNext;
    logic            reqQ, reqNext;
    logic            faultQ, faultNext;

    logic [XLEN-1:0] calcPc;
    logic            calcMisaligned;

    next_pc_calc uNextPc (
        .pc         (pcQ),
        .pcSrc      (inPCsrc),
        .imm        (inImm),
        .jumpTarget (inJumpTarget),
        .regTarget  (inRegTarget),
        .nextPc     (calcPc),
        .misaligned (calcMisaligned)
    );

    always_ff @(posedge inClk) begin
        if (inReset) begin
            state       <= S_FETCH;
            pcQ         <= RESET_PC;
            pcPlus4Q    <= RESET_PC + 32'd4;
            instrQ      <= '0;
            instrValidQ <= 1'b0;
            reqQ        <= 1'b0;
            faultQ      <= 1'b0;
        end else begin
            state       <= stateNext;
            pcQ         <= pcNext;
            pcPlus4Q    <= pcPlus4Next;
            instrQ      <= instrNext;
            instrValidQ <= instrValidNext;
            reqQ        <= reqNext;
            faultQ      <= faultNext;
        end
    end

    always_comb begin
        stateNext      = state;
        pcNext         = pcQ;
        pcPlus4Next    = pcPlus4Q;
        instrNext      = instrQ;
        instrValidNext = instrValidQ;
        reqNext        = reqQ;
        faultNext      = faultQ;
        case (state)
            S_FETCH: begin
                // The request register is low only on the first cycle after
                // reset; an ack is meaningful only while the request is up.
                if (!reqQ) begin
                    reqNext = 1'b1;
                end else if (inImemAck) begin
                    instrNext      = inImemData;
                    instrValidNext = 1'b1;
                    reqNext        = 1'b0;
                    stateNext      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (inResolve && !inStall) begin
                    instrValidNext = 1'b0;
                    if (calcMisaligned) begin
                        faultNext = 1'b1;
                        stateNext = S_HALT;
                    end else begin
                        pcNext      = calcPc;
                        pcPlus4Next = calcPc + 32'd4;
                        reqNext     = 1'b1;
                        stateNext   = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                reqNext = 1'b0;
            end
            default: begin
                stateNext = S_HALT;
                reqNext   = 1'b0;
            end
        endcase
    end

    assign outImemReq    = reqQ;
    assign outImemAddr   = pcQ;
    assign outPC         = pcQ;
    assign outPCPlus4    = pcPlus4Q;
    assign outInstr      = instrQ;
    assign outInstrValid = instrValidQ;
    assign outFault      = faultQ;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: scoreboard of expected fetch addresses
// plus a table of next-PC vectors and hand-written reset/stall/fault sequences.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        inClk = 1'b0;
    logic        inReset;
    logic [1:0]  inPCsrc;
    logic [15:0] inImm;
    logic [25:0] inJumpTarget;
    logic [31:0] inRegTarget;
    logic        inResolve;
    logic        inStall;
    logic        inImemAck;
    logic [31:0] inImemData;
    logic        outImemReq;
    logic [31:0] outImemAddr;
    logic [31:0] outInstr;
    logic        outInstrValid;
    logic [31:0] outPC;
    logic [31:0] outPCPlus4;
    logic        outFault;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .inClk         (inClk),
        .inReset       (inReset),
        .inPCsrc       (inPCsrc),
        .inImm         (inImm),
        .inJumpTarget  (inJumpTarget),
        .inRegTarget   (inRegTarget),
        .inResolve     (inResolve),
        .inStall       (inStall),
        .inImemAck     (inImemAck),
        .inImemData    (inImemData),
        .outImemReq    (outImemReq),
        .outImemAddr   (outImemAddr),
        .outInstr      (outInstr),
        .outInstrValid (outInstrValid),
        .outPC         (outPC),
        .outPCPlus4    (outPCPlus4),
        .outFault      (outFault)
    );

    always #5 inClk = ~inClk;

    typedef struct {
        logic [31:0] startPc;
        logic [1:0]  src;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] rt;
        logic [31:0] expAddr;
    } vecT;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ[$];
    logic [31:0] curPc;
    logic [31:0] curInstr;
    vecT         vecs[6];

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic doFetch(input logic [31:0] data, input int waitCycles);
        int          n;
        logic [31:0] expAddr;
        n = 0;
        while (!outImemReq && n < 20) begin
            tick();
            n++;
        end
        check("reqSeen", {31'b0, outImemReq}, 32'd1);
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboardEmpty actual=%h expected=none", outImemAddr);
            expAddr = curPc;
        end else begin
            expAddr = expQ.pop_front();
        end
        check("fetchAddr", outImemAddr, expAddr);
        check("pcEqAddr", outPC, expAddr);
        check("pcPlus4", outPCPlus4, expAddr + 32'd4);
        check("validLowInFetch", {31'b0, outInstrValid}, 32'd0);
        for (int i = 0; i < waitCycles; i++) begin
            tick();
            check("addrHeld", outImemAddr, expAddr);
            check("reqHeld", {31'b0, outImemReq}, 32'd1);
        end
        inImemAck  = 1'b1;
        inImemData = data;
        tick();
        inImemAck  = 1'b0;
        inImemData = $urandom;
        check("instrValid", {31'b0, outInstrValid}, 32'd1);
        check("instr", outInstr, data);
        check("reqDrop", {31'b0, outImemReq}, 32'd0);
        curPc    = expAddr;
        curInstr = data;
    endtask

    task automatic doResolve(input logic [1:0] src, input logic [15:0] imm,
                             input logic [25:0] jt, input logic [31:0] rt, input int stallCycles);
        inPCsrc      = src;
        inImm        = imm;
        inJumpTarget = jt;
        inRegTarget  = rt;
        inResolve    = 1'b1;
        inStall      = 1'b1;
        for (int i = 0; i < stallCycles; i++) begin
            tick();
            check("stallPc", outPC, curPc);
            check("stallInstr", outInstr, curInstr);
            check("stallNoReq", {31'b0, outImemReq}, 32'd0);
            check("stallValid", {31'b0, outInstrValid}, 32'd1);
        end
        inStall = 1'b0;
        tick();
        inResolve = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, PCSRC_BRANCH, 16'hFFFE, 26'h0, 32'h0, 32'h0000_00FC};
        vecs[1] = '{32'h0000_0100, PCSRC_BRANCH, 16'h0003, 26'h0, 32'h0, 32'h0000_0110};
        vecs[2] = '{32'h4000_0010, PCSRC_JUMP,   16'h0,    26'h0000040, 32'h0, 32'h4000_0100};
        vecs[3] = '{32'hFFFF_FFFC, PCSRC_SEQ,    16'h0,    26'h0, 32'h0, 32'h0000_0000};
        vecs[4] = '{32'h0000_0200, PCSRC_JR,     16'h0,    26'h0, 32'h0000_1234, 32'h0000_1234};
        vecs[5] = '{32'h0FFF_FFFC, PCSRC_JUMP,   16'h0,    26'h3FF_FFFF, 32'h0, 32'h1FFF_FFFC};

        inReset = 1'b1; inPCsrc = 2'b00; inImm = '0; inJumpTarget = '0; inRegTarget = '0;
        inResolve = 1'b0; inStall = 1'b0; inImemAck = 1'b0; inImemData = '0;
        curPc = RESET_PC; curInstr = '0;
        tick();
        tick();
        check("rstReq", {31'b0, outImemReq}, 32'd0);
        check("rstValid", {31'b0, outInstrValid}, 32'd0);
        check("rstFault", {31'b0, outFault}, 32'd0);
        check("rstInstr", outInstr, 32'd0);
        check("rstPc", outPC, RESET_PC);

        inReset = 1'b0;
        expQ.push_back(RESET_PC);
        tick();
        check("reqRiseAfterReset", {31'b0, outImemReq}, 32'd1);
        doFetch(32'hA000_0001, 0);
        expQ.push_back(32'h4);
        doResolve(PCSRC_SEQ, 16'h0, 26'h0, 32'h0, 0);
        doFetch(32'hA000_0002, 0);
        expQ.push_back(32'h8);
        doResolve(PCSRC_SEQ, 16'h0, 26'h0, 32'h0, 3);
        doFetch(32'hA000_0003, 5);

        foreach (vecs[k]) begin
            expQ.push_back(vecs[k].startPc);
            doResolve(PCSRC_JR, 16'h0, 26'h0, vecs[k].startPc, 0);
            doFetch($urandom, 0);
            expQ.push_back(vecs[k].expAddr);
            doResolve(vecs[k].src, vecs[k].imm, vecs[k].jt, vecs[k].rt, 0);
            doFetch($urandom, 0);
            check("noFaultVec", {31'b0, outFault}, 32'd0);
        end

        doResolve(PCSRC_JR, 16'h0, 26'h0, 32'h0000_0202, 0);
        check("faultSet", {31'b0, outFault}, 32'd1);
        check("faultNoReq", {31'b0, outImemReq}, 32'd0);
        check("faultValid", {31'b0, outInstrValid}, 32'd0);
        check("faultPcHeld", outPC, curPc);
        inImemAck = 1'b1;
        inResolve = 1'b1;
        inRegTarget = 32'h0000_0300;
        for (int i = 0; i < 4; i++) tick();
        inImemAck = 1'b0;
        inResolve = 1'b0;
        check("haltNoReq", {31'b0, outImemReq}, 32'd0);
        check("haltFaultSticky", {31'b0, outFault}, 32'd1);
        check("haltPcHeld", outPC, curPc);
        inReset = 1'b1;
        tick();
        inReset = 1'b0;
        check("faultCleared", {31'b0, outFault}, 32'd0);
        expQ.push_back(RESET_PC);
        tick();
        doFetch(32'hB000_0001, 0);

        doResolve(PCSRC_SEQ, 16'h0, 26'h0, 32'h0, 0);
        check("preResetReq", {31'b0, outImemReq}, 32'd1);
        check("preResetAddr", outImemAddr, 32'h4);
        inReset = 1'b1;
        inImemAck = 1'b1;
        inImemData = 32'hDEAD_BEEF;
        tick();
        inReset = 1'b0;
        inImemAck = 1'b0;
        check("midFetchReqLow", {31'b0, outImemReq}, 32'd0);
        check("midFetchValid", {31'b0, outInstrValid}, 32'd0);
        check("midFetchPc", outPC, RESET_PC);
        tick();
        check("midFetchValidStays", {31'b0, outInstrValid}, 32'd0);
        check("midFetchInstrClear", outInstr, 32'd0);
        expQ.push_back(RESET_PC);
        doFetch(32'hC000_0001, 0);

        inPCsrc = PCSRC_JR;
        inRegTarget = 32'h0000_0500;
        inResolve = 1'b1;
        inReset = 1'b1;
        tick();
        inReset = 1'b0;
        inResolve = 1'b0;
        check("midExecPc", outPC, RESET_PC);
        check("midExecValid", {31'b0, outInstrValid}, 32'd0);
        expQ.push_back(RESET_PC);
        doFetch(32'hC000_0002, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
